// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the pc_sequencer block (state encoding, branch types, XLEN)
package pc_seq_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALTED} state_t;
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_RSV  = 3'b011;
  localparam logic [2:0] BR_EQ   = 3'b100;
  localparam logic [2:0] BR_NE   = 3'b101;
  localparam logic [2:0] BR_LT   = 3'b110;
  localparam logic [2:0] BR_GE   = 3'b111;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake, execute-result and retire signals of the sequencer
// master = sequencer side, slave = IFU/EXU/environment side
interface pc_sequencer_if;
  import pc_seq_pkg::*;
  logic            ifu_req;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_ack;
  logic [31:0]     ifu_inst;
  logic            inst_valid;
  logic [31:0]     inst;
  logic            exu_done;
  logic [2:0]      branch;
  logic            less;
  logic            zero;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic            commit;
  logic [XLEN-1:0] commit_pc;
  logic            halted;
  logic            trap;
  modport master (
    output ifu_req, ifu_addr, inst_valid, inst, pc, commit, commit_pc, halted, trap,
    input  ifu_ack, ifu_inst, exu_done, branch, less, zero, imm, rs1, halt
  );
  modport slave (
    input  ifu_req, ifu_addr, inst_valid, inst, pc, commit, commit_pc, halted, trap,
    output ifu_ack, ifu_inst, exu_done, branch, less, zero, imm, rs1, halt
  );
endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// next_pc_calc: resolves branch condition, selects adder operands (pc/rs1, 4/imm), produces next_pc
// in: branch, less, zero, pc, imm, rs1   out: next_pc
module next_pc_calc
  import pc_seq_pkg::*;
(
  input  logic [2:0]      branch,
  input  logic            less,
  input  logic            zero,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] next_pc
);
  logic sel_imm, sel_rs1;
  logic [XLEN-1:0] sum;
  always_comb begin
    sel_rs1 = branch == BR_JALR;
    sel_imm = branch == BR_JAL || sel_rs1 || (branch == BR_EQ && zero) || (branch == BR_NE && !zero)
              || (branch == BR_LT && less) || (branch == BR_GE && !less);
    sum     = (sel_rs1 ? rs1 : pc) + (sel_imm ? imm : XLEN'(4));
    next_pc = sel_rs1 ? {sum[XLEN-1:1], 1'b0} : sum;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: BOOT/FETCH/EXEC/HALTED instruction sequencer owning the architectural PC
// ports: clk, rst_n (async active-low), bus (pc_sequencer_if.master: fetch req/ack, inst hold, exu result, commit, halted, trap)
// option: define PC_MISALIGN_TRAP_EN to halt with a sticky trap instead of jumping to a misaligned next_pc
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.master bus
);
  state_t state, state_n;
  logic [XLEN-1:0] pc_q, next_pc, commit_pc_q;
  logic [31:0] inst_q;
  logic commit_q, done, bad;
  next_pc_calc u_calc (
    .branch (bus.branch),
    .less   (bus.less),
    .zero   (bus.zero),
    .pc     (pc_q),
    .imm    (bus.imm),
    .rs1    (bus.rs1),
    .next_pc(next_pc)
  );
  assign done = state == EXEC && bus.exu_done;
`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;
  assign bad = |next_pc[1:0];
  // halt retirement takes precedence: an ebreak has no meaningful successor PC to check
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) trap_q <= 1'b0;
    else if (done && !bus.halt && bad) trap_q <= 1'b1;
  assign bus.trap = trap_q;
`else
  assign bad = 1'b0;
  assign bus.trap = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = FETCH;
      FETCH:   state_n = bus.ifu_ack ? EXEC : FETCH;
      EXEC:    state_n = bus.exu_done ? (bus.halt || bad ? HALTED : FETCH) : EXEC;
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      commit_q    <= 1'b0;
      commit_pc_q <= '0;
    end else begin
      state    <= state_n;
      commit_q <= done;
      if (state == FETCH && bus.ifu_ack) inst_q <= bus.ifu_inst;
      if (done) commit_pc_q <= pc_q;
      if (done && !bus.halt && !bad) pc_q <= next_pc;
    end
  assign bus.ifu_req    = state == FETCH;
  assign bus.inst_valid = state == EXEC;
  assign bus.halted     = state == HALTED;
  assign bus.ifu_addr   = pc_q;
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.commit     = commit_q;
  assign bus.commit_pc  = commit_pc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_sequencer_if bus ();
  pc_sequencer #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] cpc;
    logic [31:0] npc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ifu_req"}, 32'(bus.ifu_req), 0);
    chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 0);
    chk({tag, "_halted"}, 32'(bus.halted), 0);
    chk({tag, "_trap"}, 32'(bus.trap), 0);
    chk({tag, "_commit"}, 32'(bus.commit), 0);
    chk({tag, "_pc"}, bus.pc, RST_PC);
    chk({tag, "_ifu_addr"}, bus.ifu_addr, RST_PC);
    chk({tag, "_inst"}, bus.inst, 0);
    chk({tag, "_commit_pc"}, bus.commit_pc, 0);
  endtask
  task automatic wait_req();
    int n = 0;
    while (bus.ifu_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_timeout", 32'(bus.ifu_req), 1);
  endtask
  // one instruction: optional fetch delay, optional spurious strobes, then execute with given result
  task automatic run(input logic [31:0] w, input int dly, input logic [2:0] br, input logic l,
                     input logic z, input logic [31:0] im, input logic [31:0] r1, input logic h,
                     input logic stop, input logic [31:0] exp_pc, input bit spur);
    wait_req();
    chk("ifu_addr", bus.ifu_addr, m_pc);
    for (int i = 0; i < dly; i++) begin
      bus.exu_done = spur;
      bus.halt = spur;
      @(negedge clk);
      bus.exu_done = 1'b0;
      bus.halt = 1'b0;
      chk("fetch_wait_req", 32'(bus.ifu_req), 1);
      chk("fetch_wait_addr", bus.ifu_addr, m_pc);
    end
    bus.ifu_ack = 1'b1;
    bus.ifu_inst = w;
    @(negedge clk);
    bus.ifu_ack = 1'b0;
    bus.ifu_inst = '0;
    chk("exec_inst_valid", 32'(bus.inst_valid), 1);
    chk("exec_inst", bus.inst, w);
    chk("exec_ifu_req", 32'(bus.ifu_req), 0);
    if (spur) begin
      bus.ifu_ack = 1'b1;
      bus.ifu_inst = ~w;
      @(negedge clk);
      bus.ifu_ack = 1'b0;
      chk("spur_ack_inst", bus.inst, w);
      chk("spur_ack_valid", 32'(bus.inst_valid), 1);
      chk("spur_ack_pc", bus.pc, m_pc);
    end
    bus.exu_done = 1'b1;
    bus.branch = br;
    bus.less = l;
    bus.zero = z;
    bus.imm = im;
    bus.rs1 = r1;
    bus.halt = h;
    q.push_back('{m_pc, exp_pc});
    @(negedge clk);
    bus.exu_done = 1'b0;
    bus.halt = 1'b0;
    m_pc = exp_pc;
    chk("post_ifu_req", 32'(bus.ifu_req), 32'(!stop));
    chk("post_halted", 32'(bus.halted), 32'(stop));
    chk("post_addr", bus.ifu_addr, exp_pc);
  endtask
  always @(negedge clk)
    if (rst_n && bus.commit === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_commit: observed commit_pc %h expected no commit", bus.commit_pc);
      end else begin
        e = q.pop_front();
        chk("commit_pc", bus.commit_pc, e.cpc);
        chk("commit_new_pc", bus.pc, e.npc);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.ifu_ack = 0; bus.ifu_inst = 0; bus.exu_done = 0; bus.branch = 0; bus.less = 0;
    bus.zero = 0; bus.imm = 0; bus.rs1 = 0; bus.halt = 0;
    m_pc = RST_PC;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    run(32'h0000_0013, 0, BR_NONE, 0, 1, 32'h40, 0, 0, 0, 32'h8000_0004, 0);
    run(32'h00c0_006f, 0, BR_JAL, 0, 0, 32'hC, 0, 0, 0, 32'h8000_0010, 0);
    run(32'h1, 0, BR_EQ, 0, 1, 32'hFFFF_FFF0, 0, 0, 0, 32'h8000_0000, 0);
    run(32'h2, 0, BR_JAL, 0, 0, 32'h10, 0, 0, 0, 32'h8000_0010, 0);
    run(32'h3, 0, BR_EQ, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 32'h8000_0014, 0);
    run(32'h4, 0, BR_NE, 0, 0, 32'h8, 0, 0, 0, 32'h8000_001C, 0);
    run(32'h5, 0, BR_NE, 0, 1, 32'h8, 0, 0, 0, 32'h8000_0020, 0);
    run(32'h6, 0, BR_LT, 1, 0, 32'h20, 0, 0, 0, 32'h8000_0040, 0);
    run(32'h7, 0, BR_LT, 0, 0, 32'h20, 0, 0, 0, 32'h8000_0044, 0);
    run(32'h8, 0, BR_GE, 0, 0, 32'hFFFF_FFBC, 0, 0, 0, 32'h8000_0000, 0);
    run(32'h9, 0, BR_GE, 1, 0, 32'h8, 0, 0, 0, 32'h8000_0004, 0);
    run(32'hA, 0, BR_RSV, 1, 1, 32'h100, 0, 0, 0, 32'h8000_0008, 0);
    run(32'hB, 5, BR_JALR, 0, 0, 32'h4, 32'h8000_0101, 0, 0, 32'h8000_0104, 1);
    run(32'hC, 0, BR_JAL, 0, 0, 32'hFFFF_FEFC, 0, 0, 0, 32'h8000_0000, 0);
    run(32'hD, 0, BR_JAL, 0, 0, 32'h20, 0, 0, 0, 32'h8000_0020, 0);
    run(32'hE, 0, BR_JALR, 0, 0, 32'h8, 32'hFFFF_FFFC, 0, 0, 32'h0000_0004, 0);
    run(32'hF, 0, BR_JAL, 0, 0, 32'h7FFF_FFFC, 0, 0, 0, 32'h8000_0000, 0);
    run(32'h10, 0, BR_NONE, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 0);
    // reset pulse while an instruction is in EXEC with a completion strobe pending
    wait_req();
    bus.ifu_ack = 1'b1;
    bus.ifu_inst = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ifu_ack = 1'b0;
    chk("mid_exec_valid", 32'(bus.inst_valid), 1);
    bus.exu_done = 1'b1;
    bus.branch = BR_JAL;
    bus.imm = 32'h40;
    #1 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    bus.exu_done = 1'b0;
    chk_reset("held_rst");
    rst_n = 1'b1;
    m_pc = RST_PC;
    run(32'h11, 0, BR_NONE, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 0);
    run(32'h0010_0073, 2, BR_JAL, 0, 0, 32'h40, 0, 1, 1, 32'h8000_0004, 0);
    for (int i = 0; i < 3; i++) begin
      bus.ifu_ack = 1'b1;
      bus.exu_done = 1'b1;
      @(negedge clk);
      chk("halted_sticky", 32'(bus.halted), 1);
      chk("halted_no_req", 32'(bus.ifu_req), 0);
      chk("halted_no_valid", 32'(bus.inst_valid), 0);
      chk("halted_pc", bus.pc, 32'h8000_0004);
    end
    bus.ifu_ack = 1'b0;
    bus.exu_done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_after_halt");
    rst_n = 1'b1;
    m_pc = RST_PC;
`ifdef PC_MISALIGN_TRAP_EN
    run(32'h12, 0, BR_JAL, 0, 0, 32'h2, 0, 0, 1, RST_PC, 0);
    chk("trap_set", 32'(bus.trap), 1);
    repeat (2) @(negedge clk);
    chk("trap_sticky", 32'(bus.trap), 1);
    chk("trap_pc", bus.pc, RST_PC);
    chk("trap_no_req", 32'(bus.ifu_req), 0);
`else
    run(32'h12, 0, BR_JAL, 0, 0, 32'h2, 0, 0, 0, 32'h8000_0002, 0);
    chk("no_trap", 32'(bus.trap), 0);
    run(32'h13, 0, BR_NONE, 0, 0, 0, 0, 0, 0, 32'h8000_0006, 0);
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer owning the architectural PC of the NPC core. Runs a FETCH→EXEC loop per instruction: requests the instruction from the IFU, holds it for decode/execute, waits for the EXU's completion strobe, then resolves the branch condition and computes the next PC. Drives the PC adder operand selection (constant 4 vs imm, PC vs rs1) internally, so the core needs no separate branch-condition glue.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h8000_0000, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ifu_req  out  1  fetch request, level
- ifu_addr  out  XLEN  fetch address, equals pc
- ifu_ack  in  1  fetch complete, ifu_inst valid this cycle
- ifu_inst  in  32  fetched instruction
- inst_valid  out  1  inst held and valid for decode/execute
- inst  out  32  latched instruction
- exu_done  in  1  execute finished; branch/less/zero/imm/rs1/halt valid this cycle
- branch  in  3  branch type (encoding below)
- less  in  1  ALU less flag
- zero  in  1  ALU zero flag
- imm  in  XLEN  immediate
- rs1  in  XLEN  rs1 value
- halt  in  1  ebreak-class stop request, sampled with exu_done
- pc  out  XLEN  current PC
- commit  out  1  one-cycle retire pulse
- commit_pc  out  XLEN  PC of retired instruction
- halted  out  1  sequencer stopped
- trap  out  1  misaligned-target trap (only with PC_MISALIGN_TRAP_EN, else tied 0)

## Operation
- States: BOOT, FETCH, EXEC, HALTED. Reset → BOOT; BOOT → FETCH unconditionally after one cycle.
- FETCH: ifu_req=1, ifu_addr=pc. On ifu_ack: inst←ifu_inst, → EXEC. No ack: stay, address stable.
- EXEC: inst_valid=1. On exu_done: halt=1 → HALTED (pc unchanged); else pc←next_pc, → FETCH.
- HALTED: absorbing until reset; ifu_req=0, inst_valid=0, halted=1.
- Branch encoding / next_pc: 000 pc+4; 001 (jal) pc+imm; 010 (jalr) (rs1+imm)&~1; 011 reserved, pc+4; 100 beq: zero?pc+imm:pc+4; 101 bne: !zero; 110 blt/bltu: less; 111 bge/bgeu: !less.
- Arithmetic modulo 2^XLEN; wrap-around is not an error.
- commit registered: high exactly one cycle after exu_done accepted in EXEC (including halt retirement); commit_pc = PC of that instruction.
- ifu_ack outside FETCH and exu_done outside EXEC ignored; halt ignored without exu_done.

## Timing
- Reset values: state BOOT, pc=RESET_PC, inst=0, commit_pc=0, ifu_req=0, inst_valid=0, commit=0, halted=0, trap=0.
- ifu_req, inst_valid, halted decoded from state register (no combinational path from inputs).
- ifu_ack may arrive in the first FETCH cycle: minimum 2 cycles/instruction (1 FETCH + 1 EXEC).
- New pc visible in the cycle commit is high; ifu_req reasserts that same cycle with new address.
- rst_n asserted mid-fetch or mid-exec: immediate return to reset values; pending handshakes dropped.

## Configuration
- PC_MISALIGN_TRAP_EN defined: if computed next_pc[1:0]≠0 on exu_done, pc not updated, → HALTED, trap=1 (sticky), commit still pulses; no fetch issued to the bad address.
- Undefined: next_pc taken as computed regardless of alignment; trap port constant 0.

## Structure
- Package pc_seq_pkg: state enum (BOOT/FETCH/EXEC/HALTED), branch-type localparams (BR_NONE, BR_JAL, BR_JALR, BR_EQ, BR_NE, BR_LT, BR_GE).
- One combinational sub-module next_pc_calc: branch/less/zero/pc/imm/rs1 → operand selects (4 vs imm, pc vs rs1) and next_pc.
- FSM, pc register, inst latch and commit register in pc_sequencer.

## Test plan
- Reset release, ifu_ack same cycle as first req → ifu_addr=0x8000_0000; exu_done branch=000 → commit pulse, commit_pc=0x8000_0000, pc=0x8000_0004.
- beq: pc=0x8000_0010, imm=0xFFFF_FFF0, zero=1 → pc=0x8000_0000; zero=0 → 0x8000_0014; repeat bne/blt/bge with inverted/less flags.
- jalr: rs1=0x8000_0101, imm=4 → pc=0x8000_0104; jal imm=0x20 from 0x8000_0000 → 0x8000_0020.
- ifu_ack delayed 5 cycles; spurious exu_done during FETCH and spurious ifu_ack during EXEC → no state change, ifu_addr stable, no commit.
- exu_done+halt → one commit, halted=1 thereafter, ifu_req stays 0; rst_n pulse mid-EXEC → all outputs return to reset values, restart at RESET_PC.
- With PC_MISALIGN_TRAP_EN: jal imm=2 → trap=1, halted=1, pc unchanged; without macro → pc=pc+2, fetch proceeds.
